// File: rtl/rgb_pwm_pkg.sv
// Shared constants and types for the RGB PWM duty/stuck decoder.
// Channel indices give each colour's bit position in the stuck vector.
package rgb_pwm_pkg;

    localparam int DEFAULT_WINDOW = 1200;

    localparam int CH_R = 2;
    localparam int CH_G = 1;
    localparam int CH_B = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH
    } chan_state_t;

endpackage

// File: rtl/pwm_channel_meter.sv
// One colour channel: synchronizes the PWM line, counts high samples and rising
// edges over the current window, and latches duty/stuck when the window closes.
module pwm_channel_meter
    import rgb_pwm_pkg::*;
#(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm,
    input  logic             win_end,
    output logic [CNT_W-1:0] duty,
    output logic             stuck
);

    logic [1:0]       sync_ff;
    logic [1:0]       primed;
    chan_state_t      state;
    logic [CNT_W-1:0] high_cnt;
    logic             edge_seen;
    logic             s;
    logic             rise;
    logic [CNT_W-1:0] s_ext;

    assign s     = sync_ff[1];
    assign s_ext = CNT_W'(s);
    // Only a sample preceded by a known-low sample is an edge; IDLE->HIGH is not.
    assign rise  = (state == ST_LOW) && s;

    // The state machine waits in IDLE until the synchronizer holds a real sample,
    // so an input already high at reset release never registers as an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_ff   <= 2'b00;
            primed    <= 2'b00;
            state     <= ST_IDLE;
            high_cnt  <= '0;
            edge_seen <= 1'b0;
            duty      <= '0;
            stuck     <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[0], pwm};
            primed  <= {primed[0], 1'b1};
            if (primed[1]) begin
                state <= s ? ST_HIGH : ST_LOW;
            end
            if (win_end) begin
                duty      <= high_cnt + s_ext;
                stuck     <= ~(edge_seen | rise);
                high_cnt  <= '0;
                edge_seen <= 1'b0;
            end else begin
                high_cnt <= high_cnt + s_ext;
                if (rise) begin
                    edge_seen <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rgb_pwm_decoder.sv
// Measures duty and edge activity of the three LED PWM lines over a fixed
// window, publishing results with a one-cycle valid strobe per window.
module rgb_pwm_decoder
    import rgb_pwm_pkg::*;
#(
    parameter int WINDOW = DEFAULT_WINDOW,
    parameter int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_r,
    input  logic             pwm_g,
    input  logic             pwm_b,
    output logic [CNT_W-1:0] duty_r,
    output logic [CNT_W-1:0] duty_g,
    output logic [CNT_W-1:0] duty_b,
    output logic [2:0]       stuck,
    output logic             valid
);

    localparam int             WIN_W    = $clog2(WINDOW);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    logic [WIN_W-1:0] win_cnt;
    logic             win_end;

    assign win_end = (win_cnt == WIN_LAST);

    // valid is registered on the same edge the channels latch their results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt <= '0;
            valid   <= 1'b0;
        end else begin
            win_cnt <= win_end ? '0 : win_cnt + 1'b1;
            valid   <= win_end;
        end
    end

    pwm_channel_meter #(.CNT_W(CNT_W)) u_meter_r (
        .clk     (clk),
        .reset   (reset),
        .pwm     (pwm_r),
        .win_end (win_end),
        .duty    (duty_r),
        .stuck   (stuck[CH_R])
    );

    pwm_channel_meter #(.CNT_W(CNT_W)) u_meter_g (
        .clk     (clk),
        .reset   (reset),
        .pwm     (pwm_g),
        .win_end (win_end),
        .duty    (duty_g),
        .stuck   (stuck[CH_G])
    );

    pwm_channel_meter #(.CNT_W(CNT_W)) u_meter_b (
        .clk     (clk),
        .reset   (reset),
        .pwm     (pwm_b),
        .win_end (win_end),
        .duty    (duty_b),
        .stuck   (stuck[CH_B])
    );

endmodule

// File: tb/tb_rgb_pwm_decoder.sv
// Directed bench for rgb_pwm_decoder with WINDOW=16: table of PWM patterns with
// hand-computed duty/stuck results, plus reset, hold and long-run sequences.
module tb_rgb_pwm_decoder;

    localparam int WINDOW = 16;
    localparam int CNT_W  = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             pwm_r = 1'b0;
    logic             pwm_g = 1'b0;
    logic             pwm_b = 1'b0;
    logic [CNT_W-1:0] duty_r;
    logic [CNT_W-1:0] duty_g;
    logic [CNT_W-1:0] duty_b;
    logic [2:0]       stuck;
    logic             valid;

    int checks = 0;
    int errors = 0;

    // Pattern per channel: high while (phase % period) < high_len.
    int pr = 1, hr = 0, pg = 1, hg = 0, pb = 1, hb = 0;
    int ph = 0;

    typedef struct {
        int         pr, hr, pg, hg, pb, hb;
        int         exp_r, exp_g, exp_b;
        logic [2:0] exp_stuck;
    } vec_t;

    vec_t vecs[5];

    rgb_pwm_decoder #(.WINDOW(WINDOW)) dut (
        .clk    (clk),
        .reset  (reset),
        .pwm_r  (pwm_r),
        .pwm_g  (pwm_g),
        .pwm_b  (pwm_b),
        .duty_r (duty_r),
        .duty_g (duty_g),
        .duty_b (duty_b),
        .stuck  (stuck),
        .valid  (valid)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            ph++;
            pwm_r = ((ph % pr) < hr);
            pwm_g = ((ph % pg) < hg);
            pwm_b = ((ph % pb) < hb);
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic waitValid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (valid !== 1'b1 && n < 40);
    endtask

    task automatic applyStimulus(input int a, input int b, input int c,
                                 input int d, input int e, input int f);
        pr = a; hr = b; pg = c; hg = d; pb = e; hb = f;
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_state", int'({duty_r, duty_g, duty_b, stuck, valid}), 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        logic [CNT_W-1:0] held;

        vecs[0] = '{1, 0, 1, 0, 1, 0,   0,  0, 0, 3'b111};
        vecs[1] = '{1, 0, 1, 1, 1, 0,   0, 16, 0, 3'b111};
        vecs[2] = '{8, 2, 1, 0, 1, 0,   4,  0, 0, 3'b011};
        vecs[3] = '{4, 2, 8, 2, 1, 0,   8,  4, 0, 3'b001};
        vecs[4] = '{16, 15, 2, 1, 4, 1, 15, 8, 4, 3'b000};

        repeat (3) @(negedge clk);
        checkOutput("reset_initial", int'({duty_r, duty_g, duty_b, stuck, valid}), 0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].pr, vecs[i].hr, vecs[i].pg, vecs[i].hg,
                          vecs[i].pb, vecs[i].hb);
            applyReset();
            waitValid(n);
            checkOutput("first_valid_cycle", n, WINDOW);
            if (i == 0) begin
                checkOutput("first_win_duty", int'({duty_r, duty_g, duty_b}), 0);
                checkOutput("first_win_stuck", int'(stuck), 7);
            end
            waitValid(n);
            checkOutput("valid_spacing", n, WINDOW);
            waitValid(n);
            checkOutput("valid_spacing", n, WINDOW);
            checkOutput("duty_r", int'(duty_r), vecs[i].exp_r);
            checkOutput("duty_g", int'(duty_g), vecs[i].exp_g);
            checkOutput("duty_b", int'(duty_b), vecs[i].exp_b);
            checkOutput("stuck", int'(stuck), int'(vecs[i].exp_stuck));
        end

        // Reset at window cycle 9 discards the partial window.
        repeat (9) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("midreset_outputs", int'({duty_r, duty_g, duty_b, stuck, valid}), 0);
        end
        reset = 1'b0;
        waitValid(n);
        checkOutput("midreset_next_valid", n, WINDOW);

        // Results hold between strobes even when the inputs change.
        held = duty_r;
        applyStimulus(1, 0, 1, 0, 1, 0);
        repeat (8) @(negedge clk);
        checkOutput("duty_hold", int'(duty_r), int'(held));

        applyStimulus(4, 2, 8, 2, 1, 0);
        waitValid(n);
        for (int w = 0; w < 100; w++) begin
            waitValid(n);
            checkOutput("long_spacing", n, WINDOW);
            checkOutput("long_duty_bound", int'(duty_r > 16 || duty_g > 16 || duty_b > 16), 0);
        end
        checkOutput("long_duty_r", int'(duty_r), 8);
        checkOutput("long_stuck", int'(stuck), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_decoder.md
RGB_PWM_DECODER -- requirements
Module: rgb_pwm_decoder

Interface
REQ-001 Parameter WINDOW, default 1200: measurement window length in clk cycles (100 us at 12 MHz); legal range 2..65535.
REQ-002 Parameter CNT_W, default $clog2(WINDOW+1): width of duty outputs.
REQ-003 clk  input  1  system clock; the block uses this single clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pwm_r, pwm_g, pwm_b  input  1 each  asynchronous PWM LED drive signals, the same R/G/B lines the LED top drives.
REQ-006 duty_r, duty_g, duty_b  output  CNT_W each  high-sample count of the last completed window.
REQ-007 stuck  output  3  per-channel flag, no rising edge in the last window; bit 2=R, bit 1=G, bit 0=B.
REQ-008 valid  output  1  one-cycle strobe, duty/stuck updated this cycle.

Function
REQ-009 Each input SHALL pass through a 2-flop synchronizer, 2-cycle latency; all measurement uses the synchronized value s.
REQ-010 A shared window counter SHALL count 0..WINDOW-1 and wrap to 0, advancing every cycle when reset is low.
REQ-011 Per channel, high_cnt SHALL add 1 on each cycle s=1; the cycle with window counter = WINDOW-1 is included.
REQ-012 Per channel, a rising edge SHALL be s=1 while the previous s was 0; edge_seen sets on any rising edge within the window.
REQ-013 On the edge where window counter = WINDOW-1: duty_x <= high_cnt + s; stuck[x] <= ~(edge_seen | rise this cycle); high_cnt <= 0; edge_seen <= 0; valid <= 1.
REQ-014 valid SHALL be high exactly one cycle, then low for WINDOW-1 cycles; period WINDOW cycles.
REQ-015 duty_x range SHALL be 0..WINDOW inclusive; no overflow, no saturation logic needed given CNT_W.
REQ-016 duty and stuck SHALL hold their values between valid strobes.
REQ-017 Constant-high input SHALL give duty=WINDOW with stuck=1; constant-low SHALL give duty=0 with stuck=1.
REQ-018 A rise that straddles a window boundary SHALL count in the window containing the cycle where s first reads 1.
REQ-019 Channels SHALL be fully independent; simultaneous edges on all three SHALL not interact.
REQ-020 Per-channel state machine: IDLE (after reset, previous-sample unknown) -> LOW or HIGH on first synchronized sample; LOW->HIGH counts as an edge; IDLE->HIGH SHALL NOT count as an edge.

Reset
REQ-021 While reset is high: synchronizers, window counter, high_cnt, edge_seen = 0; channel state = IDLE; duty_x = 0, stuck = 3'b000, valid = 0.
REQ-022 Reset asserted mid-window SHALL discard the partial window; no valid is issued for it.
REQ-023 After reset release, the first valid SHALL occur WINDOW cycles after the first rising clk edge with reset low.

Structure
REQ-024 Package rgb_pwm_pkg SHALL hold the WINDOW default, the channel index constants (R=2, G=1, B=0), and the channel state enum (IDLE, LOW, HIGH).
REQ-025 Sub-module pwm_channel_meter (synchronizer, state machine, high_cnt, edge_seen, latched duty/stuck) SHALL be instantiated three times; the top holds the window counter and valid.

Verification (benches use WINDOW=16)
REQ-026 All inputs held 0 after reset -> first valid at cycle 16; duty_r/g/b = 0; stuck = 3'b111.
REQ-027 pwm_g held 1 from reset onward -> duty_g = 16 every window; stuck[1] = 1 (IDLE->HIGH is not an edge).
REQ-028 pwm_r with period 8, 2 high and 6 low, started before reset release -> steady-state duty_r = 4, stuck[2] = 0.
REQ-029 Simultaneous stimulus R at 50%/period 4, G at 25%/period 8, B at 0 -> duty = 8, 4, 0; stuck = 3'b001.
REQ-030 Reset pulsed at window cycle 9, released 3 cycles later -> valid stays low; outputs = 0; next valid exactly 16 cycles after release.
REQ-031 Continuous run of 100 windows -> valid spacing always 16 cycles; duty never exceeds 16.
